// File: rtl/bch_31_pkg.sv
// Shared GF(2^5) constants, FSM state type and a constant-multiply helper for
// the BCH(31,21) Chien search stage.
package bch_31_pkg;

  localparam int GF_W = 5;
  localparam int N    = 31;

  localparam logic [GF_W-1:0] ALPHA_INV  = 5'b10010;
  localparam logic [GF_W-1:0] ALPHA_INV2 = 5'b01001;
  localparam logic [GF_W:0]   PRIM_POLY  = 6'b100101;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  // Shift-and-add product reduced by the primitive polynomial.
  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b);
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[GF_W-1] ? ({sh[GF_W-2:0], 1'b0} ^ PRIM_POLY[GF_W-1:0])
                      : {sh[GF_W-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/bch_31_chien_if.sv
// Handshake and data bundle between the locator solver, the Chien search
// stage and its consumer.
interface bch_31_chien_if;

  logic        in_valid;
  logic        in_ready;
  logic [4:0]  lambda1;
  logic [4:0]  lambda2;
  logic [30:0] cw_in;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] cw_out;
  logic [30:0] err_mask;
  logic [1:0]  err_cnt;
  logic        fail;

  modport master (
    output in_valid, lambda1, lambda2, cw_in, out_ready,
    input  in_ready, out_valid, cw_out, err_mask, err_cnt, fail
  );

  modport slave (
    input  in_valid, lambda1, lambda2, cw_in, out_ready,
    output in_ready, out_valid, cw_out, err_mask, err_cnt, fail
  );

endinterface

// File: rtl/bch_31_chien_gf_const_mul.sv
// Combinational GF(2^5) multiply of a variable operand by a fixed constant;
// synthesis folds the constant into a small XOR network.
module gf_const_mul
  import bch_31_pkg::*;
#(
  parameter logic [GF_W-1:0] C = 5'b00001
) (
  input  logic [GF_W-1:0] a_i,
  output logic [GF_W-1:0] p_o
);

  assign p_o = gf_mul(a_i, C);

endmodule

// File: rtl/bch_31_chien.sv
// Iterative Chien search and correction for BCH(31,21), t=2: one locator
// evaluation per clock. Optional macro BCH_CHIEN_EARLY_EXIT_EN stops early.
module bch_31_chien #(
  parameter int N = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  bch_31_chien_if.slave         bus
);

  import bch_31_pkg::state_e;
  import bch_31_pkg::IDLE;
  import bch_31_pkg::SEARCH;
  import bch_31_pkg::DONE;
  import bch_31_pkg::GF_W;
  import bch_31_pkg::ALPHA_INV;
  import bch_31_pkg::ALPHA_INV2;

  function automatic logic [1:0] deg_of(input logic [GF_W-1:0] l1,
                                        input logic [GF_W-1:0] l2);
    if (l2 != '0)      return 2'd2;
    else if (l1 != '0) return 2'd1;
    else               return 2'd0;
  endfunction

  state_e          state_q, state_d;
  logic [GF_W-1:0] r1_q, r1_d, r2_q, r2_d, r1_nx, r2_nx;
  logic [4:0]      k_q, k_d;
  logic [N-1:0]    mask_q, mask_d, cw_q, cw_d;
  logic [1:0]      deg_q, deg_d, cnt_q, cnt_d;

  logic            ov_q, ov_d, fail_q, fail_d;
  logic [N-1:0]    cwo_q, cwo_d, em_q, em_d;
  logic [1:0]      ec_q, ec_d;

  logic            hit, last;
  logic [N-1:0]    mask_hit;
  logic [1:0]      cnt_hit;

  gf_const_mul #(.C(ALPHA_INV))  u_mul_r1 (.a_i(r1_q), .p_o(r1_nx));
  gf_const_mul #(.C(ALPHA_INV2)) u_mul_r2 (.a_i(r2_q), .p_o(r2_nx));

  // Root test at the current position: Lambda(alpha^-k) = 1 + r1 + r2.
  assign hit      = ((5'b00001 ^ r1_q ^ r2_q) == '0);
  assign mask_hit = mask_q | (hit ? (N'(1) << k_q) : '0);
  assign cnt_hit  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + {1'b0, hit};

`ifdef BCH_CHIEN_EARLY_EXIT_EN
  assign last = (k_q == 5'(N-1)) || (cnt_hit == deg_q);
`else
  assign last = (k_q == 5'(N-1));
`endif

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    k_d     = k_q;
    mask_d  = mask_q;
    cw_d    = cw_q;
    deg_d   = deg_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    cwo_d   = cwo_q;
    em_d    = em_q;
    ec_d    = ec_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cw_d    = bus.cw_in;
          r1_d    = bus.lambda1;
          r2_d    = bus.lambda2;
          k_d     = '0;
          mask_d  = '0;
          cnt_d   = '0;
          deg_d   = deg_of(bus.lambda1, bus.lambda2);
          state_d = SEARCH;
`ifdef BCH_CHIEN_EARLY_EXIT_EN
          // A constant locator has no roots: publish the word unchanged.
          if (deg_of(bus.lambda1, bus.lambda2) == 2'd0) begin
            state_d = DONE;
            ov_d    = 1'b1;
            cwo_d   = bus.cw_in;
            em_d    = '0;
            ec_d    = 2'd0;
            fail_d  = 1'b0;
          end
`endif
        end
      end
      SEARCH: begin
        r1_d   = r1_nx;
        r2_d   = r2_nx;
        mask_d = mask_hit;
        cnt_d  = cnt_hit;
        if (last) begin
          state_d = DONE;
          ov_d    = 1'b1;
          em_d    = mask_hit;
          ec_d    = cnt_hit;
          fail_d  = (cnt_hit != deg_q);
          cwo_d   = (cnt_hit != deg_q) ? cw_q : (cw_q ^ mask_hit);
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and published results are reset; working registers load on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      cwo_q   <= '0;
      em_q    <= '0;
      ec_q    <= 2'd0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      cwo_q   <= cwo_d;
      em_q    <= em_d;
      ec_q    <= ec_d;
      fail_q  <= fail_d;
    end
  end

  always_ff @(posedge clk) begin
    r1_q   <= r1_d;
    r2_q   <= r2_d;
    k_q    <= k_d;
    mask_q <= mask_d;
    cw_q   <= cw_d;
    deg_q  <= deg_d;
    cnt_q  <= cnt_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.cw_out    = cwo_q;
  assign bus.err_mask  = em_q;
  assign bus.err_cnt   = ec_q;
  assign bus.fail      = fail_q;

endmodule
